// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one RAM port between instruction fetch and data memory.
// One RAM transaction is outstanding at a time. Address, store data and enables are
// latched at grant and held until the RAM answers ACCESS. An ERROR answer inserts a
// one-cycle RETRY gap with the enables low, then the same transaction is reissued.
// Instruction fetch is protected from data starvation by a saturating counter.
//
// Ports:
//   CLK, nRST            clock (rising edge), synchronous active-low reset
//   iREN, iaddr          instruction read request and word address
//   dREN, dWEN           data read / write request (never both high)
//   daddr, dstore        data address and store data
//   halt                 pipeline halted: no new instruction grants
//   ramstate, ramload    RAM status (FREE/BUSY/ACCESS/ERROR) and read data
//   iwait, dwait         per-requester stall, low for the completion cycle only
//   iload, dload         read data (live on completion, held afterwards)
//   ramREN, ramWEN       RAM enables
//   ramaddr, ramstore    RAM address and write data
module memory_arbiter #(
  parameter int unsigned DATA_STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic        halt,
  input  logic [1:0]  ramstate,
  input  logic [31:0] ramload,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore
);

  localparam logic [1:0] RamAccess = 2'd2;
  localparam logic [1:0] RamError  = 2'd3;
  localparam logic [3:0] StarveMax = 4'(DATA_STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StData, StInstr, StRetry} state_e;

  state_e      state_q, state_d;
  logic        owner_data_q, owner_data_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic        ren_q, ren_d;
  logic        wen_q, wen_d;
  logic [31:0] iload_q, iload_d;
  logic [31:0] dload_q, dload_d;
  logic [3:0]  starve_q, starve_d;

  logic in_txn, i_done, d_done, d_win, i_win;

  always_comb begin
    in_txn = (state_q == StData) || (state_q == StInstr);
    i_done = (state_q == StInstr) && (ramstate == RamAccess);
    d_done = (state_q == StData) && (ramstate == RamAccess);
    // Data normally wins, but yields once it has starved a pending, unhalted fetch.
    d_win  = (dREN || dWEN) && ((starve_q < StarveMax) || !iREN || halt);
    i_win  = iREN && !halt;
  end

  always_comb begin
    state_d      = state_q;
    owner_data_d = owner_data_q;
    addr_d       = addr_q;
    store_d      = store_q;
    ren_d        = ren_q;
    wen_d        = wen_q;
    unique case (state_q)
      StIdle: begin
        if (d_win) begin
          state_d      = StData;
          owner_data_d = 1'b1;
          addr_d       = daddr;
          ren_d        = dREN;
          wen_d        = dWEN;
          if (dWEN) store_d = dstore;
        end else if (i_win) begin
          state_d      = StInstr;
          owner_data_d = 1'b0;
          addr_d       = iaddr;
          ren_d        = 1'b1;
          wen_d        = 1'b0;
        end
      end
      StData, StInstr: begin
        if (ramstate == RamAccess)     state_d = StIdle;
        else if (ramstate == RamError) state_d = StRetry;
      end
      StRetry: state_d = owner_data_q ? StData : StInstr;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (d_done) begin
      if (!iREN)                     starve_d = 4'd0;
      else if (starve_q < StarveMax) starve_d = starve_q + 4'd1;
    end else if (i_done) begin
      starve_d = 4'd0;
    end
    iload_d = i_done ? ramload : iload_q;
    dload_d = (d_done && ren_q) ? ramload : dload_q;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= StIdle;
      owner_data_q <= 1'b0;
      addr_q       <= '0;
      store_q      <= '0;
      ren_q        <= 1'b0;
      wen_q        <= 1'b0;
      iload_q      <= '0;
      dload_q      <= '0;
      starve_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_data_q <= owner_data_d;
      addr_q       <= addr_d;
      store_q      <= store_d;
      ren_q        <= ren_d;
      wen_q        <= wen_d;
      iload_q      <= iload_d;
      dload_q      <= dload_d;
      starve_q     <= starve_d;
    end
  end

  // Latched enables are kept through RETRY for the reissue; only the outputs are gated.
  assign ramREN   = in_txn && ren_q;
  assign ramWEN   = in_txn && wen_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign iwait    = !i_done;
  assign dwait    = !d_done;
  assign iload    = iload_d;
  assign dload    = dload_d;

endmodule
